// File: rtl/specrx_pkg.sv
//------------------------------------------------------------------------------
// Module  : specrx_pkg
// Brief   : Shared FSM state encoding and sizing helpers for the readout receiver.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package specrx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        RESYNC = 2'd2
    } state_t;

    // Beats per word: two bits arrive per beat.
    function automatic int specrx_nb(input int word_w);
        return word_w / 2;
    endfunction

    function automatic int specrx_cnt_w(input int word_w);
        return $clog2(word_w / 2) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/specrx_if.sv
//------------------------------------------------------------------------------
// Module  : specrx_if
// Brief   : Valid/ready word handshake between the receiver and host capture.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface specrx_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] rx_data;
    logic              rx_is_time;
    logic              rx_valid;
    logic              rx_ready;

    modport master (output rx_data, output rx_is_time, output rx_valid, input  rx_ready);
    modport slave  (input  rx_data, input  rx_is_time, input  rx_valid, output rx_ready);
endinterface

`default_nettype wire

// File: rtl/specrx_fifo.sv
//------------------------------------------------------------------------------
// Module  : specrx_fifo
// Brief   : Output buffer; FIFO_DEPTH-entry ring with SPECRX_FIFO_EN, else one register.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module specrx_fifo #(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              push,
    input  wire logic              push_is_time,
    input  wire logic [WORD_W-1:0] push_data,
    input  wire logic              pop_ready,
    output logic [WORD_W-1:0]      head_data,
    output logic                   head_is_time,
    output logic                   head_valid,
    output logic                   overflow
);

    typedef struct packed {
        logic              is_time;
        logic [WORD_W-1:0] data;
    } entry_t;

    logic   w_full;
    logic   w_pop;
    logic   w_push_ok;
    entry_t w_in;
    logic   r_overflow;

    assign w_in      = '{is_time: push_is_time, data: push_data};
    assign w_push_ok = push & (~w_full | w_pop);
    assign overflow  = r_overflow;

`ifdef SPECRX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    entry_t           r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    assign head_valid   = (r_count != '0);
    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop        = head_valid & pop_ready;
    assign head_data    = r_mem[r_rptr].data;
    assign head_is_time = r_mem[r_rptr].is_time;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= push & ~w_push_ok;
            if (w_push_ok) begin
                r_mem[r_wptr] <= w_in;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
`else
    entry_t r_entry;
    logic   r_valid;

    assign head_valid   = r_valid;
    assign w_full       = r_valid;
    assign w_pop        = r_valid & pop_ready;
    assign head_data    = r_entry.data;
    assign head_is_time = r_entry.is_time;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= push & ~w_push_ok;
            if (w_push_ok) begin
                r_entry <= w_in;
                r_valid <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/spectrogram_readout_rx.sv
//------------------------------------------------------------------------------
// Module  : spectrogram_readout_rx
// Brief   : Two-lane serial readout deserializer with buffered valid/ready output.
//           Define SPECRX_FIFO_EN for a FIFO_DEPTH-entry output FIFO.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module spectrogram_readout_rx
    import specrx_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic       input_serial_readout_clk,
    input  wire logic       reset,
    input  wire logic       sending_data,
    input  wire logic [1:0] serial_in,
    input  wire logic       SL_time,
    input  wire logic       SL_ch,
    specrx_if.master        rx,
    output logic            err_framing,
    output logic            err_overflow,
    output logic            busy
);

    localparam int NB    = specrx_nb(WORD_W);
    localparam int CNT_W = specrx_cnt_w(WORD_W);

    state_t              r_state;
    logic [WORD_W-3:0]   r_shift;
    logic                r_kind;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic                r_push;
    logic                r_push_is_time;
    logic [WORD_W-1:0]   r_push_data;
    logic                r_err_framing;
    logic                w_beat;

    assign w_beat      = sending_data & (SL_time ^ SL_ch);
    assign busy        = (r_state != IDLE);
    assign err_framing = r_err_framing;

    // r_shift keeps only the bits received so far; the final beat is merged on push.
    always_ff @(posedge input_serial_readout_clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_shift        <= '0;
            r_kind         <= 1'b0;
            r_beat_cnt     <= '0;
            r_push         <= 1'b0;
            r_push_is_time <= 1'b0;
            r_push_data    <= '0;
            r_err_framing  <= 1'b0;
        end else begin
            r_push        <= 1'b0;
            r_err_framing <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_beat) begin
                        r_shift    <= (WORD_W-2)'(serial_in);
                        r_kind     <= SL_time;
                        r_beat_cnt <= CNT_W'(1);
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_beat && (SL_time == r_kind)) begin
                        r_shift    <= (WORD_W-2)'({r_shift, serial_in});
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        if (r_beat_cnt == CNT_W'(NB - 1)) begin
                            r_push         <= 1'b1;
                            r_push_is_time <= r_kind;
                            r_push_data    <= {r_shift, serial_in};
                            r_beat_cnt     <= '0;
                            r_state        <= IDLE;
                        end
                    end else begin
                        r_err_framing <= 1'b1;
                        r_beat_cnt    <= '0;
                        r_state       <= RESYNC;
                    end
                end
                RESYNC: begin
                    if (!sending_data) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    specrx_fifo #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (input_serial_readout_clk),
        .rst          (reset),
        .push         (r_push),
        .push_is_time (r_push_is_time),
        .push_data    (r_push_data),
        .pop_ready    (rx.rx_ready),
        .head_data    (rx.rx_data),
        .head_is_time (rx.rx_is_time),
        .head_valid   (rx.rx_valid),
        .overflow     (err_overflow)
    );

endmodule

`default_nettype wire

// File: tb/tb_spectrogram_readout_rx.sv
//------------------------------------------------------------------------------
// Module  : tb_spectrogram_readout_rx
// Brief   : Scoreboard bench for spectrogram_readout_rx (directed + random words).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spectrogram_readout_rx;

    localparam int W  = 16;
    localparam int NB = W / 2;
    localparam int D  = 4;
`ifdef SPECRX_FIFO_EN
    localparam int CAP = D;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sending_data = 1'b0;
    logic [1:0] serial_in = 2'b00;
    logic       SL_time = 1'b0;
    logic       SL_ch = 1'b0;
    logic       err_framing, err_overflow, busy;

    specrx_if #(.WORD_W(W)) rxif ();

    spectrogram_readout_rx #(.WORD_W(W), .FIFO_DEPTH(D)) dut (
        .input_serial_readout_clk (clk),
        .reset                    (reset),
        .sending_data             (sending_data),
        .serial_in                (serial_in),
        .SL_time                  (SL_time),
        .SL_ch                    (SL_ch),
        .rx                       (rxif),
        .err_framing              (err_framing),
        .err_overflow             (err_overflow),
        .busy                     (busy)
    );

    always #5 clk = ~clk;

    logic [W:0] exp_q[$];
    int n_cmp = 0, n_bad = 0;
    int obs_fr = 0, obs_ov = 0, exp_fr = 0, exp_ov = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the presented head with the oldest expected word.
    always @(negedge clk) begin
        if (!reset) begin
            if (err_framing)  obs_fr++;
            if (err_overflow) obs_ov++;
            if (rxif.rx_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", {rxif.rx_is_time, rxif.rx_data});
                end else begin
                    check("rx_head", 32'({rxif.rx_is_time, rxif.rx_data}), 32'(exp_q[0]));
                    if (rxif.rx_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic beat(input logic sd, input logic [1:0] bits, input logic t, input logic c);
        @(posedge clk); #2;
        sending_data = sd; serial_in = bits; SL_time = t; SL_ch = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] word, input logic kind, input logic expect_push);
        if (expect_push) exp_q.push_back({kind, word});
        for (int b = 0; b < NB; b++) beat(1'b1, word[W-1-2*b -: 2], kind, ~kind);
    endtask

    task automatic send_partial(input logic [W-1:0] word, input logic kind, input int k);
        for (int b = 0; b < k; b++) beat(1'b1, word[W-1-2*b -: 2], kind, ~kind);
    endtask

    task automatic drain(input logic random_ready);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            @(posedge clk); #2;
            rxif.rx_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        @(posedge clk); #2;
        rxif.rx_ready = 1'b1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] w;
        logic         k;
        int           nb, f;
        rxif.rx_ready = 1'b1;
        #13;
        check("rst_valid", 32'(rxif.rx_valid), 0);
        check("rst_data",  32'(rxif.rx_data), 0);
        check("rst_istime", 32'(rxif.rx_is_time), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_errs",  32'({err_framing, err_overflow}), 0);
        @(posedge clk); #2; reset = 1'b0;
        idle(2);

        // Single timestamp with latency check.
        send_word(16'hA53C, 1'b1, 1'b1);
        @(posedge clk); #2;
        check("lat_not_yet", 32'(rxif.rx_valid), 0);
        sending_data = 1'b0; SL_time = 1'b0;
        @(posedge clk); #2;
        check("lat_valid", 32'(rxif.rx_valid), 1);
        idle(3);

        // Back-to-back timestamp then channel word.
        send_word(16'h1234, 1'b1, 1'b1);
        send_word(16'h00FF, 1'b0, 1'b1);
        idle(4);
        check("b2b_framing", 32'(obs_fr), 32'(exp_fr));

        // sending_data drops mid-word, then a good word.
        send_partial(16'h7777, 1'b1, 3);
        beat(1'b0, 2'b00, 1'b0, 1'b0); exp_fr++;
        idle(1);
        send_word(16'hBEEF, 1'b1, 1'b1);
        idle(4);
        check("drop_framing", 32'(obs_fr), 32'(exp_fr));

        // Both markers on beat 2; link stays active so the next word is ignored.
        send_partial(16'hC0DE, 1'b0, 2);
        beat(1'b1, 2'b11, 1'b1, 1'b1); exp_fr++;
        send_word(16'hDEAD, 1'b0, 1'b0);
        idle(1);
        send_word(16'h4321, 1'b0, 1'b1);
        idle(4);
        check("both_framing", 32'(obs_fr), 32'(exp_fr));

        // Overflow: consumer stalled, one word too many.
        rxif.rx_ready = 1'b0;
        for (int i = 0; i <= CAP; i++)
            send_word(W'($urandom), 1'(i % 2), (i < CAP) ? 1'b1 : 1'b0);
        exp_ov++;
        idle(4);
        check("ovf_count", 32'(obs_ov), 32'(exp_ov));
        check("ovf_held",  32'(rxif.rx_valid), 1);
        drain(1'b1);

        // Randomized words with occasional framing faults.
        for (int it = 0; it < 40; it++) begin
            w = W'($urandom);
            k = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                nb = $urandom_range(1, NB - 1);
                f  = $urandom_range(0, 3);
                send_partial(w, k, nb);
                case (f)
                    0:       beat(1'b0, 2'b00, k, ~k);
                    1:       beat(1'b1, 2'b01, 1'b1, 1'b1);
                    2:       beat(1'b1, 2'b10, 1'b0, 1'b0);
                    default: beat(1'b1, 2'b11, ~k, k);
                endcase
                exp_fr++;
                idle(1);
            end else begin
                send_word(w, k, 1'b1);
            end
            for (int g = $urandom_range(0, 2); g > 0; g--)
                beat(1'($urandom_range(0, 1)), 2'b00, 1'b0, 1'b0);
        end
        idle(4);
        check("rand_framing", 32'(obs_fr), 32'(exp_fr));
        check("rand_overflow", 32'(obs_ov), 32'(exp_ov));
        drain(1'b0);

        // Reset with buffered words and a partial word in flight.
        rxif.rx_ready = 1'b0;
        for (int i = 0; i < ((CAP < 2) ? CAP : 2); i++) send_word(W'($urandom), 1'b1, 1'b1);
        send_partial(16'hF00D, 1'b0, 3);
        @(posedge clk); #3;
        check("pre_rst_busy",  32'(busy), 1);
        check("pre_rst_valid", 32'(rxif.rx_valid), 1);
        sending_data = 1'b0; SL_ch = 1'b0;
        reset = 1'b1;
        #1;
        check("async_valid", 32'(rxif.rx_valid), 0);
        check("async_data",  32'({rxif.rx_is_time, rxif.rx_data}), 0);
        check("async_busy",  32'(busy), 0);
        check("async_errs",  32'({err_framing, err_overflow}), 0);
        exp_q.delete();
        @(posedge clk); #2; reset = 1'b0;
        rxif.rx_ready = 1'b1;
        idle(2);
        send_word(16'h5A5A, 1'b0, 1'b1);
        idle(4);
        drain(1'b0);
        check("final_framing", 32'(obs_fr), 32'(exp_fr));
        check("final_overflow", 32'(obs_ov), 32'(exp_ov));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
